// File: rtl/multi_timer_master.sv
// rtl/multi_timer_master.sv - keypad digit-entry master for the wall clock and NUM_TIMERS alarm timers
// Optional: define MTM_ENTRY_TIMEOUT_EN to abandon a stale partial entry after TIMEOUT_CYC quiet cycles.
module multi_timer_master #(
    parameter int NUM_TIMERS  = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                            mclk,
    input  logic                            mrst_n,
    input  logic [5:0]                      key_code,
    output logic [4:0]                      now_h,
    output logic [5:0]                      now_m,
    output logic                            set,
    output logic [5*NUM_TIMERS-1:0]         timer_h,
    output logic [6*NUM_TIMERS-1:0]         timer_m,
    output logic [NUM_TIMERS-1:0]           run_enable,
    output logic                            key_err,
    output logic [$clog2(NUM_TIMERS+1)-1:0] field,
    output logic [4*(NUM_TIMERS+1)-1:0]     bitmap
);
    localparam int            FW         = $clog2(NUM_TIMERS + 1);
    localparam logic [FW-1:0] LAST_FIELD = FW'(NUM_TIMERS);

    localparam logic [5:0] K_RESET = 6'd1;
    localparam logic [5:0] K_CLOCK = 6'd2;
    localparam logic [5:0] K_ENTER = 6'd3;
    localparam logic [5:0] K_SHIFT = 6'd4;
    localparam logic [5:0] K_AD    = 6'd8;
    localparam logic [5:0] K_ID    = 6'd12;

    typedef enum logic [1:0] {EDIT, ARMED, IDLE} state_t;

    state_t        state;
    logic [2:0]    pos;
    logic [3:0]    dbuf [0:3];
    logic [5:0]    key_prev;
    logic          press;
    logic          is_digit;
    logic          digit_ok;
    logic          timeout_hit;
    logic [3:0]    digit;
    logic [6:0]    hour_try;
    logic [2:0]    pos_dec;
    logic [FW-1:0] field_inc;
    logic [FW-1:0] field_dec;
    logic [4:0]    commit_h;
    logic [5:0]    commit_m;

    assign press     = (key_prev == 6'd0) && (key_code != 6'd0);
    assign pos_dec   = pos - 3'd1;
    assign hour_try  = 7'(dbuf[0]) * 7'd10 + 7'(digit);
    assign commit_h  = 5'(dbuf[0]) * 5'd10 + 5'(dbuf[1]);
    assign commit_m  = 6'(dbuf[2]) * 6'd10 + 6'(dbuf[3]);
    assign field_inc = (field == LAST_FIELD) ? '0 : field + 1'b1;
    assign field_dec = (field == '0) ? LAST_FIELD : field - 1'b1;

    // Keypad matrix wiring puts digits at scattered scan codes
    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (key_code)
            6'd5:    digit = 4'd9;
            6'd6:    digit = 4'd6;
            6'd7:    digit = 4'd3;
            6'd9:    digit = 4'd8;
            6'd10:   digit = 4'd5;
            6'd11:   digit = 4'd2;
            6'd13:   digit = 4'd7;
            6'd14:   digit = 4'd4;
            6'd15:   digit = 4'd1;
            6'd16:   digit = 4'd0;
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        digit_ok = 1'b0;
        case (pos)
            3'd0:    digit_ok = (digit <= 4'd2);
            3'd1:    digit_ok = (hour_try <= 7'd23);
            3'd2:    digit_ok = (digit <= 4'd5);
            3'd3:    digit_ok = 1'b1;
            default: digit_ok = 1'b0;
        endcase
    end

`ifdef MTM_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;
    logic          entry_live;

    assign entry_live  = (state != IDLE) && (pos != 3'd0);
    assign timeout_hit = entry_live && !press && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n)
            idle_cnt <= '0;
        else if (press || !entry_live || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            key_prev   <= '0;
            state      <= EDIT;
            pos        <= '0;
            field      <= '0;
            now_h      <= '0;
            now_m      <= '0;
            timer_h    <= '0;
            timer_m    <= '0;
            run_enable <= '0;
            set        <= 1'b0;
            key_err    <= 1'b0;
            for (int i = 0; i < 4; i++) dbuf[i] <= '0;
        end else begin
            key_prev <= key_code;
            set      <= 1'b0;
            key_err  <= 1'b0;
            if (press && key_code == K_RESET) begin
                // key_prev still tracks the held RESET key so a release is required
                state      <= EDIT;
                pos        <= '0;
                field      <= '0;
                now_h      <= '0;
                now_m      <= '0;
                timer_h    <= '0;
                timer_m    <= '0;
                run_enable <= '0;
                for (int i = 0; i < 4; i++) dbuf[i] <= '0;
            end else if (press) begin
                case (key_code)
                    K_CLOCK, K_AD, K_ID: begin
                        if (key_code == K_CLOCK)   field <= '0;
                        else if (key_code == K_AD) field <= field_inc;
                        else                       field <= field_dec;
                        pos   <= '0;
                        state <= EDIT;
                        for (int i = 0; i < 4; i++) dbuf[i] <= '0;
                    end
                    K_ENTER: begin
                        if (state == ARMED) begin
                            if (field == '0) begin
                                now_h <= commit_h;
                                now_m <= commit_m;
                                set   <= 1'b1;
                            end
                            for (int k = 0; k < NUM_TIMERS; k++) begin
                                if (field == FW'(k + 1)) begin
                                    timer_h[5*k +: 5] <= commit_h;
                                    timer_m[6*k +: 6] <= commit_m;
                                    run_enable[k]     <= 1'b1;
                                end
                            end
                            pos <= '0;
                            for (int i = 0; i < 4; i++) dbuf[i] <= '0;
                            if (field == LAST_FIELD) begin
                                state <= IDLE;
                            end else begin
                                field <= field_inc;
                                state <= EDIT;
                            end
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                    K_SHIFT: begin
                        if (state == IDLE) begin
                            key_err <= 1'b1;
                        end else if (pos != 3'd0) begin
                            pos                 <= pos_dec;
                            dbuf[pos_dec[1:0]]  <= '0;
                            state               <= EDIT;
                        end else if (field == '0) begin
                            key_err <= 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_TIMERS; k++)
                                if (field == FW'(k + 1)) run_enable[k] <= 1'b0;
                        end
                    end
                    default: begin
                        if (is_digit && state == EDIT && digit_ok) begin
                            dbuf[pos[1:0]] <= digit;
                            pos            <= pos + 3'd1;
                            if (pos == 3'd3) state <= ARMED;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                pos     <= '0;
                key_err <= 1'b1;
                state   <= EDIT;
                for (int i = 0; i < 4; i++) dbuf[i] <= '0;
            end
        end
    end

    // Active-low cursor: one digit while editing, the whole field once armed
    always_comb begin
        bitmap = '1;
        for (int f = 0; f <= NUM_TIMERS; f++) begin
            for (int p = 0; p < 4; p++) begin
                if (field == FW'(f) && state == EDIT && pos == 3'(p)) bitmap[4*f+p] = 1'b0;
                if (field == FW'(f) && state == ARMED)                bitmap[4*f+p] = 1'b0;
            end
        end
    end
endmodule
